// File: rtl/protect_sequencer.sv
// Power-stage protection sequencer: PFC soft-start, inverter enable, fault trip/hold/lock.
// Optional macro FAULT_AUTO_RETRY_EN enables automatic restart after the hold period.
module protect_sequencer #(
    parameter logic [15:0] START_DLY = 16'd5000,
    parameter logic [15:0] HOLD_CYC  = 16'd50000,
    parameter logic [1:0]  MAX_RETRY = 2'd3
) (
    input  logic       CLK_50M,
    input  logic       Rst,
    input  logic       Run_En,
    input  logic       Fault_Clr,
    input  logic [5:0] Flt_n,
    output logic       PFC_En,
    output logic       Inv1_En,
    output logic       Inv2_En,
    output logic       Fault_Int,
    output logic [5:0] Fault_Code,
    output logic [5:0] Fault_All,
    output logic [2:0] State,
    output logic [1:0] Retry_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_TRIP  = 3'd3,
        S_HOLD  = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

`ifdef FAULT_AUTO_RETRY_EN
    localparam logic AUTO_RETRY = 1'b1;
`else
    localparam logic AUTO_RETRY = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        run_s1_q, run_s2_q;
    logic        clr_s1_q, clr_s2_q, clr_s3_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pfc_q, pfc_d;
    logic        inv_q, inv_d;
    logic        fint_q, fint_d;
    logic [5:0]  code_q, code_d;
    logic [5:0]  all_q, all_d;
    logic [1:0]  retry_q, retry_d;

    logic        run_ok, clr_rise, flt_ok;
    logic        start_done, hold_done, clear_ok, retry_ok, retry_go;

    assign run_ok     = run_s2_q;
    assign clr_rise   = clr_s2_q & ~clr_s3_q;
    assign flt_ok     = (Flt_n == 6'h3F);
    // Counter holds cycles already spent in the state; a zero delay exits at once.
    assign start_done = (START_DLY == 16'd0) || (cnt_q >= START_DLY - 16'd1);
    assign hold_done  = (HOLD_CYC == 16'd0) || (cnt_q >= HOLD_CYC - 16'd1);
    assign clear_ok   = (state_q == S_LOCK) && clr_rise && flt_ok;
    assign retry_ok   = AUTO_RETRY && (retry_q < MAX_RETRY) && flt_ok && run_ok;
    assign retry_go   = (state_q == S_HOLD) && (state_d == S_START);

    // State, synchronizer and output registers
    always_ff @(posedge CLK_50M or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            clr_s3_q <= 1'b0;
            cnt_q    <= 16'd0;
            pfc_q    <= 1'b0;
            inv_q    <= 1'b0;
            fint_q   <= 1'b1;
            code_q   <= 6'd0;
            all_q    <= 6'd0;
            retry_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            run_s1_q <= Run_En;
            run_s2_q <= run_s1_q;
            clr_s1_q <= Fault_Clr;
            clr_s2_q <= clr_s1_q;
            clr_s3_q <= clr_s2_q;
            cnt_q    <= cnt_d;
            pfc_q    <= pfc_d;
            inv_q    <= inv_d;
            fint_q   <= fint_d;
            code_q   <= code_d;
            all_q    <= all_d;
            retry_q  <= retry_d;
        end
    end

    // Next-state logic; a fault outranks a run-command drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run_ok && flt_ok) state_d = S_START;
            S_START: begin
                if (!flt_ok)         state_d = S_TRIP;
                else if (!run_ok)    state_d = S_IDLE;
                else if (start_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (!flt_ok)      state_d = S_TRIP;
                else if (!run_ok) state_d = S_IDLE;
            end
            S_TRIP:  state_d = S_HOLD;
            S_HOLD:  if (hold_done) state_d = retry_ok ? S_START : S_LOCK;
            S_LOCK:  if (clear_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge
    always_comb begin
        pfc_d   = (state_d == S_START) || (state_d == S_RUN);
        inv_d   = (state_d == S_RUN);
        fint_d  = fint_q;
        code_d  = code_q;
        all_d   = all_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;

        if (state_d != state_q)
            cnt_d = 16'd0;
        else if (((state_q == S_START) || (state_q == S_HOLD)) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;

        if (state_d == S_TRIP) begin
            fint_d = 1'b0;
            if (code_q == 6'd0)
                code_d = ~Flt_n;
        end
        if ((state_d == S_TRIP) || (state_d == S_HOLD) || (state_d == S_LOCK))
            all_d = all_q | ~Flt_n;

        if (retry_go) begin
            fint_d  = 1'b1;
            retry_d = retry_q + 2'd1;
        end

        if (clear_ok) begin
            fint_d  = 1'b1;
            code_d  = 6'd0;
            all_d   = 6'd0;
            retry_d = 2'd0;
        end
    end

    assign PFC_En     = pfc_q;
    assign Inv1_En    = inv_q;
    assign Inv2_En    = inv_q;
    assign Fault_Int  = fint_q;
    assign Fault_Code = code_q;
    assign Fault_All  = all_q;
    assign State      = state_q;
    assign Retry_Cnt  = retry_q;

endmodule

// File: tb/tb_protect_sequencer.sv
// Directed bench for protect_sequencer with START_DLY=5, HOLD_CYC=10, MAX_RETRY=2.
// The retry scenario is selected by FAULT_AUTO_RETRY_EN, matching the DUT build.
module tb_protect_sequencer;

    logic       CLK_50M;
    logic       Rst;
    logic       Run_En;
    logic       Fault_Clr;
    logic [5:0] Flt_n;
    logic       PFC_En, Inv1_En, Inv2_En, Fault_Int;
    logic [5:0] Fault_Code, Fault_All;
    logic [2:0] State;
    logic [1:0] Retry_Cnt;

    int checks = 0;
    int errors = 0;

    protect_sequencer #(
        .START_DLY(16'd5),
        .HOLD_CYC (16'd10),
        .MAX_RETRY(2'd2)
    ) dut (
        .CLK_50M   (CLK_50M),
        .Rst       (Rst),
        .Run_En    (Run_En),
        .Fault_Clr (Fault_Clr),
        .Flt_n     (Flt_n),
        .PFC_En    (PFC_En),
        .Inv1_En   (Inv1_En),
        .Inv2_En   (Inv2_En),
        .Fault_Int (Fault_Int),
        .Fault_Code(Fault_Code),
        .Fault_All (Fault_All),
        .State     (State),
        .Retry_Cnt (Retry_Cnt)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge CLK_50M);
        #1;
    endtask

    // Single-cycle Fault_Clr pulse; the DUT acts on it 3 edges after it is raised
    task automatic pulse_clr();
        Fault_Clr = 1'b1;
        tick(1);
        Fault_Clr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Run_En = 1'b0; Fault_Clr = 1'b0; Flt_n = 6'h3F;
        tick(3);
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
        checks++; if ({PFC_En, Inv1_En, Inv2_En} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b want 000", {PFC_En, Inv1_En, Inv2_En}); end
        checks++; if (Fault_Int !== 1'b1) begin errors++; $display("FAIL reset_int: got %b want 1", Fault_Int); end
        checks++; if ({Fault_Code, Fault_All, Retry_Cnt} !== 14'd0) begin errors++; $display("FAIL reset_codes: got %h/%h/%0d want 0/0/0", Fault_Code, Fault_All, Retry_Cnt); end
        Rst = 1'b0;
        tick(1);
    endtask

    task automatic test_normal_start();
        Run_En = 1'b1;
        tick(2);
        checks++; if (PFC_En !== 1'b0) begin errors++; $display("FAIL start_pfc_early: got %b want 0", PFC_En); end
        tick(1);
        checks++; if (PFC_En !== 1'b1) begin errors++; $display("FAIL start_pfc: got %b want 1", PFC_En); end
        checks++; if (State !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", State); end
        tick(4);
        checks++; if (Inv1_En !== 1'b0) begin errors++; $display("FAIL start_inv_early: got %b want 0", Inv1_En); end
        tick(1);
        checks++; if ({PFC_En, Inv1_En, Inv2_En} !== 3'b111) begin errors++; $display("FAIL run_en: got %b want 111", {PFC_En, Inv1_En, Inv2_En}); end
        checks++; if (State !== 3'd2) begin errors++; $display("FAIL run_state: got %0d want 2", State); end
    endtask

    task automatic test_trip();
        Flt_n = 6'b111101;
        tick(1);
        checks++; if ({PFC_En, Inv1_En, Inv2_En} !== 3'b000) begin errors++; $display("FAIL trip_en: got %b want 000", {PFC_En, Inv1_En, Inv2_En}); end
        checks++; if (State !== 3'd3) begin errors++; $display("FAIL trip_state: got %0d want 3", State); end
        checks++; if (Fault_Code !== 6'h02) begin errors++; $display("FAIL trip_code: got %h want 02", Fault_Code); end
        checks++; if (Fault_Int !== 1'b0) begin errors++; $display("FAIL trip_int: got %b want 0", Fault_Int); end
        Flt_n = 6'h3F;
        Run_En = 1'b0;
        tick(1);
        checks++; if (State !== 3'd4) begin errors++; $display("FAIL hold_enter: got %0d want 4", State); end
        tick(9);
        checks++; if (State !== 3'd4) begin errors++; $display("FAIL hold_last: got %0d want 4", State); end
        tick(1);
        checks++; if (State !== 3'd5) begin errors++; $display("FAIL lock_enter: got %0d want 5", State); end
        checks++; if ({Fault_Code, Fault_Int, Retry_Cnt} !== {6'h02, 1'b0, 2'd0}) begin errors++; $display("FAIL lock_regs: got %h/%b/%0d want 02/0/0", Fault_Code, Fault_Int, Retry_Cnt); end
    endtask

    task automatic test_clear();
        Flt_n = 6'b111110;
        pulse_clr();
        tick(4);
        checks++; if (State !== 3'd5) begin errors++; $display("FAIL clr_blocked_state: got %0d want 5", State); end
        checks++; if ({Fault_Code, Fault_All, Fault_Int} !== {6'h02, 6'h03, 1'b0}) begin errors++; $display("FAIL clr_blocked_regs: got %h/%h/%b want 02/03/0", Fault_Code, Fault_All, Fault_Int); end
        Flt_n = 6'h3F;
        pulse_clr();
        tick(1);
        checks++; if (State !== 3'd5) begin errors++; $display("FAIL clr_sync_delay: got %0d want 5", State); end
        tick(1);
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL clr_state: got %0d want 0", State); end
        checks++; if ({Fault_Code, Fault_All, Fault_Int, Retry_Cnt} !== {6'h00, 6'h00, 1'b1, 2'd0}) begin errors++; $display("FAIL clr_regs: got %h/%h/%b/%0d want 00/00/1/0", Fault_Code, Fault_All, Fault_Int, Retry_Cnt); end
    endtask

    task automatic test_precedence();
        Run_En = 1'b1;
        tick(8);
        checks++; if (State !== 3'd2) begin errors++; $display("FAIL prec_run: got %0d want 2", State); end
        Flt_n = 6'b101110;
        tick(1);
        checks++; if ({State, Fault_Code} !== {3'd3, 6'h11}) begin errors++; $display("FAIL prec_first: got %0d/%h want 3/11", State, Fault_Code); end
        Flt_n = 6'h3F;
        Run_En = 1'b0;
        tick(1);
        Flt_n = 6'b111011;
        Fault_Clr = 1'b1;
        tick(1);
        checks++; if ({State, Fault_Code, Fault_All} !== {3'd4, 6'h11, 6'h15}) begin errors++; $display("FAIL prec_hold: got %0d/%h/%h want 4/11/15", State, Fault_Code, Fault_All); end
        Flt_n = 6'h3F;
        Fault_Clr = 1'b0;
        tick(9);
        checks++; if ({State, Fault_Code, Fault_All} !== {3'd5, 6'h11, 6'h15}) begin errors++; $display("FAIL prec_lock: got %0d/%h/%h want 5/11/15", State, Fault_Code, Fault_All); end
        pulse_clr();
        tick(2);
        checks++; if ({State, Fault_Code} !== {3'd0, 6'h00}) begin errors++; $display("FAIL prec_clear: got %0d/%h want 0/00", State, Fault_Code); end
    endtask

    task automatic test_run_abort();
        Run_En = 1'b1;
        tick(8);
        Run_En = 1'b0;
        tick(2);
        checks++; if ({State, PFC_En} !== {3'd2, 1'b1}) begin errors++; $display("FAIL abort_delay: got %0d/%b want 2/1", State, PFC_En); end
        tick(1);
        checks++; if ({State, PFC_En, Inv1_En, Inv2_En} !== {3'd0, 3'b000}) begin errors++; $display("FAIL abort_idle: got %0d/%b want 0/000", State, {PFC_En, Inv1_En, Inv2_En}); end
        checks++; if ({Fault_Int, Fault_Code} !== {1'b1, 6'h00}) begin errors++; $display("FAIL abort_nofault: got %b/%h want 1/00", Fault_Int, Fault_Code); end
        Run_En = 1'b1;
        tick(8);
        Run_En = 1'b0;
        tick(2);
        Flt_n = 6'b111110;
        tick(1);
        checks++; if ({State, Fault_Code, Fault_Int} !== {3'd3, 6'h01, 1'b0}) begin errors++; $display("FAIL abort_fault_wins: got %0d/%h/%b want 3/01/0", State, Fault_Code, Fault_Int); end
        Flt_n = 6'h3F;
        tick(11);
        checks++; if (State !== 3'd5) begin errors++; $display("FAIL abort_lock: got %0d want 5", State); end
        pulse_clr();
        tick(2);
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL abort_clear: got %0d want 0", State); end
    endtask

`ifdef FAULT_AUTO_RETRY_EN
    task automatic test_retry();
        Run_En = 1'b1;
        tick(8);
        for (int k = 1; k <= 3; k++) begin
            Flt_n = 6'b111110;
            tick(1);
            checks++; if (State !== 3'd3) begin errors++; $display("FAIL retry_trip%0d: got %0d want 3", k, State); end
            Flt_n = 6'h3F;
            tick(11);
            if (k < 3) begin
                checks++; if ({State, Retry_Cnt, Fault_Int, Fault_Code, PFC_En} !== {3'd1, k[1:0], 1'b1, 6'h01, 1'b1})
                    begin errors++; $display("FAIL retry_restart%0d: got %0d/%0d/%b/%h/%b want 1/%0d/1/01/1", k, State, Retry_Cnt, Fault_Int, Fault_Code, PFC_En, k); end
                tick(5);
                checks++; if (State !== 3'd2) begin errors++; $display("FAIL retry_run%0d: got %0d want 2", k, State); end
            end else begin
                checks++; if ({State, Retry_Cnt, Fault_Int} !== {3'd5, 2'd2, 1'b0})
                    begin errors++; $display("FAIL retry_lock: got %0d/%0d/%b want 5/2/0", State, Retry_Cnt, Fault_Int); end
            end
        end
        Run_En = 1'b0;
        pulse_clr();
        tick(2);
        checks++; if ({State, Retry_Cnt} !== {3'd0, 2'd0}) begin errors++; $display("FAIL retry_clear: got %0d/%0d want 0/0", State, Retry_Cnt); end
    endtask
`else
    task automatic test_retry_disabled();
        Run_En = 1'b1;
        tick(8);
        Flt_n = 6'b111110;
        tick(1);
        Flt_n = 6'h3F;
        tick(11);
        checks++; if ({State, Retry_Cnt, Fault_Int} !== {3'd5, 2'd0, 1'b0}) begin errors++; $display("FAIL noretry_lock: got %0d/%0d/%b want 5/0/0", State, Retry_Cnt, Fault_Int); end
        Run_En = 1'b0;
        pulse_clr();
        tick(2);
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL noretry_clear: got %0d want 0", State); end
    endtask
`endif

    task automatic test_reset_mid_run();
        Run_En = 1'b1;
        tick(8);
        checks++; if ({State, PFC_En} !== {3'd2, 1'b1}) begin errors++; $display("FAIL rst_pre_run: got %0d/%b want 2/1", State, PFC_En); end
        #5;
        Rst = 1'b1;
        #1;
        checks++; if ({PFC_En, Inv1_En, Inv2_En} !== 3'b000) begin errors++; $display("FAIL rst_async_en: got %b want 000", {PFC_En, Inv1_En, Inv2_En}); end
        checks++; if ({State, Fault_Int} !== {3'd0, 1'b1}) begin errors++; $display("FAIL rst_async_state: got %0d/%b want 0/1", State, Fault_Int); end
        Rst = 1'b0;
        tick(1);
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL rst_release: got %0d want 0", State); end
        Run_En = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_start();
        test_trip();
        test_clear();
        test_precedence();
        test_run_abort();
`ifdef FAULT_AUTO_RETRY_EN
        test_retry();
`else
        test_retry_disabled();
`endif
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/protect_sequencer.md
PROTECT_SEQUENCER -- requirements
Module: protect_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- START_DLY, 16'd5000, PFC-only soft-start cycles before the inverters are enabled.
- HOLD_CYC, 16'd50000, post-trip lockout cycles (1 ms at 50 MHz).
- MAX_RETRY, 2'd3, automatic restart attempts allowed before lock.

REQ-002 The block SHALL have one clock, CLK_50M, and reset Rst, which is asynchronous and active-high. Ports (clock and reset first):
- CLK_50M  in   1  system clock.
- Rst      in   1  asynchronous active-high reset.
- Run_En   in   1  DSP run command, level, asynchronous.
- Fault_Clr  in  1  DSP fault-clear request, asynchronous, acted on at its rising edge.
- Flt_n    in   6  filtered fault flags, active-low, synchronous to CLK_50M; bit order {OP_Ovp2_F, InvOcp2_F, OP_Ovp1_F, InvOcp1_F, IP_Ocp_F, BusOvp_F}.
- PFC_En   out  1  input-stage PWM enable.
- Inv1_En  out  1  inverter 1 PWM enable.
- Inv2_En  out  1  inverter 2 PWM enable.
- Fault_Int  out  1  fault interrupt to the DSP, active-low.
- Fault_Code  out  6  first-fault snapshot, active-high, same bit order as Flt_n.
- Fault_All  out  6  sticky OR of every fault seen since the last clear.
- State    out  3  current FSM state encoding.
- Retry_Cnt  out  2  restart attempts used.

Function
REQ-003 Run_En and Fault_Clr SHALL each pass through a 2-flop synchronizer; Fault_Clr edge detection SHALL be performed on the synchronized signal.
REQ-004 The FSM states SHALL be IDLE=0, START=1, RUN=2, TRIP=3, HOLD=4, LOCK=5. All outputs SHALL be registered.
REQ-005 IDLE: all enables 0. Go to START when synchronized Run_En=1 and Flt_n=6'h3F.
REQ-006 START: PFC_En=1, Inv1_En=0, Inv2_En=0. The counter runs for START_DLY cycles, then the FSM goes to RUN.
REQ-007 RUN: PFC_En, Inv1_En and Inv2_En are all 1.
REQ-008 In START or RUN, any Flt_n bit at 0 SHALL move the FSM to TRIP. All enables SHALL read 0 on the edge after the fault is sampled (1-cycle latency).
REQ-009 In START or RUN, synchronized Run_En=0 with no fault SHALL return the FSM to IDLE with enables 0 and no fault recorded. If a fault and Run_En=0 occur in the same cycle, the fault wins and the FSM goes to TRIP.
REQ-010 TRIP lasts one cycle:
- Fault_Code <= ~Flt_n as sampled at the trip edge, only if Fault_Code==0 (first fault only).
- Fault_Int <= 0.
- Hold counter loads 0.
- Next state is HOLD.
REQ-011 Fault_All SHALL OR in ~Flt_n every cycle in TRIP, HOLD and LOCK.
REQ-012 HOLD: enables remain 0 for HOLD_CYC cycles. On expiry the next state is decided by REQ-017.
REQ-013 LOCK: enables 0. A synchronized Fault_Clr rising edge while Flt_n=6'h3F SHALL:
- clear Fault_Code, Fault_All and Retry_Cnt;
- set Fault_Int <= 1;
- move the FSM to IDLE.
A Fault_Clr edge while any fault is still active SHALL be ignored.
REQ-014 A Fault_Clr edge in any state other than LOCK SHALL have no effect.
REQ-015 Counters SHALL saturate and never wrap. Comparisons SHALL be done on the full 16 bits.

Reset
REQ-016 While Rst=1, the block SHALL immediately force:
- State=IDLE;
- PFC_En=0, Inv1_En=0, Inv2_En=0;
- Fault_Int=1;
- Fault_Code=0, Fault_All=0, Retry_Cnt=0;
- all counters and synchronizers to 0.
Reset asserted mid-RUN SHALL drop all enables asynchronously.

Configuration
REQ-017 FAULT_AUTO_RETRY_EN SHALL select the HOLD-expiry behaviour:
- Defined: if Retry_Cnt<MAX_RETRY and Flt_n=6'h3F and synchronized Run_En=1, then Retry_Cnt increments, Fault_Int returns to 1, Fault_Code and Fault_All are retained, and the FSM goes to START. Otherwise it goes to LOCK.
- Undefined: HOLD always goes to LOCK, and Retry_Cnt stays 0.

Verification (START_DLY=5, HOLD_CYC=10, MAX_RETRY=2)
REQ-018 Normal start: Run_En=1, no faults.
- PFC_En=1 3 cycles later (2 sync + 1 FSM).
- Inv1_En=Inv2_En=1 5 cycles after that.
- State=2.
REQ-019 Trip: in RUN, Flt_n=6'b111101 for 1 cycle.
- Next edge: all enables 0, Fault_Code=6'h02, Fault_Int=0.
- FSM reaches LOCK after 10 HOLD cycles (macro undefined).
REQ-020 Fault precedence:
- Simultaneous bit0 and bit4 low gives Fault_Code=6'h11.
- A later bit2 fault in HOLD leaves Fault_Code=6'h11 and gives Fault_All=6'h15.
REQ-021 Clear handling:
- In LOCK, a Fault_Clr pulse with bit0 still low gives no change.
- With faults removed, the next Fault_Clr pulse gives IDLE, Fault_Int=1 and codes 0.
REQ-022 With FAULT_AUTO_RETRY_EN defined:
- Three successive trips give Retry_Cnt 1, then 2.
- The third trip goes to LOCK with Retry_Cnt=2.
REQ-023 Reset during RUN: Rst pulsed for 1 ns mid-cycle drops enables at once. After release, State=0.
